// File: rtl/fetch_stage.sv
// IF stage of the 19-bit core: PC register, imem address, IF/ID register, halt FSM; optional FETCH_PERF_CNT_EN counters.
// Latency: imem_addr is combinational from pc; fetched instruction appears on IF/ID one cycle later.
// Backpressure: stall holds pc/IF/ID/state; redirect overrides stall and inserts one bubble.
module fetch_stage #(
    parameter int                  ADDR_W     = 12,
    parameter int                  INSTR_W    = 19,
    parameter logic [ADDR_W-1:0]   RESET_PC   = '0,
    parameter logic [INSTR_W-1:0]  HALT_INSTR = '1,
    parameter logic [INSTR_W-1:0]  NOP_INSTR  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_data,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic [INSTR_W-1:0]  ifid_instr,
    output logic [ADDR_W-1:0]   ifid_pc1,
    output logic                ifid_valid,
    output logic                halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]         fetch_cnt,
    output logic [15:0]         stall_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    pc_nxt;
    logic [ADDR_W-1:0]    pc_inc;
    logic [INSTR_W-1:0]   instr_nxt;
    logic [ADDR_W-1:0]    pc1_nxt;
    logic                 valid_nxt;
    logic                 is_halt_instr;
    logic                 fetch_take;
    logic                 stall_take;

    assign imem_addr     = pc;
    assign pc_inc        = pc + ADDR_W'(1);
    assign is_halt_instr = (imem_data == HALT_INSTR);
    assign stall_take    = !redirect && stall;
    assign fetch_take    = !redirect && !stall && (state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = ST_RUN;
        end else if (stall) begin
            state_nxt = state;
        end else if (state == ST_RUN && is_halt_instr) begin
            state_nxt = ST_HALT;
        end
    end

    always_comb begin
        halted = (state == ST_HALT);
    end

    // Datapath next values; a bubble keeps ifid_pc1 so decode still sees the last real PC+1.
    always_comb begin
        pc_nxt    = pc;
        instr_nxt = ifid_instr;
        pc1_nxt   = ifid_pc1;
        valid_nxt = ifid_valid;
        if (redirect) begin
            pc_nxt    = redirect_pc;
            instr_nxt = NOP_INSTR;
            valid_nxt = 1'b0;
        end else if (stall) begin
            pc_nxt = pc;
        end else if (state == ST_RUN) begin
            instr_nxt = imem_data;
            pc1_nxt   = pc_inc;
            valid_nxt = 1'b1;
            if (!is_halt_instr) begin
                pc_nxt = pc_inc;
            end
        end else begin
            instr_nxt = NOP_INSTR;
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            ifid_instr <= NOP_INSTR;
            ifid_pc1   <= '0;
            ifid_valid <= 1'b0;
        end else begin
            pc         <= pc_nxt;
            ifid_instr <= instr_nxt;
            ifid_pc1   <= pc1_nxt;
            ifid_valid <= valid_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fetch_take && fetch_cnt != 16'hFFFF) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (stall_take && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_take;
    assign unused_take = fetch_take ^ stall_take;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model holds mem[i] = i+1, except mem[7] = HALT.
module tb_fetch_stage;

    logic         clk;
    logic         rst_n;
    logic [11:0]  imem_addr;
    logic [18:0]  imem_data;
    logic         stall;
    logic         redirect;
    logic [11:0]  redirect_pc;
    logic [18:0]  ifid_instr;
    logic [11:0]  ifid_pc1;
    logic         ifid_valid;
    logic         halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]  fetch_cnt;
    logic [15:0]  stall_cnt;
`endif

    logic [18:0]  mem [4096];
    int           checks = 0;
    int           errors = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifid_instr  (ifid_instr),
        .ifid_pc1    (ifid_pc1),
        .ifid_valid  (ifid_valid),
        .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [18:0] instr,
                              input logic [11:0] pc1, input logic valid);
        check({tag, "_instr"}, 32'(ifid_instr), 32'(instr));
        check({tag, "_pc1"},   32'(ifid_pc1),   32'(pc1));
        check({tag, "_valid"}, 32'(ifid_valid), 32'(valid));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 19'(i + 1);
        mem[7]      = 19'h7FFFF;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 12'd0;
        #12;
        check("rst_addr",   32'(imem_addr), 32'd0);
        check_ifid("rst", 19'h0, 12'd0, 1'b0);
        check("rst_halted", 32'(halted), 32'd0);

        // release away from the edge; first fetch of address 0 on the next edge
        @(negedge clk);
        rst_n = 1'b1;
        step(); check_ifid("f1", 19'd1, 12'd1, 1'b1);
        step(); check_ifid("f2", 19'd2, 12'd2, 1'b1);
        step(); check_ifid("f3", 19'd3, 12'd3, 1'b1);
        check("f3_addr", 32'(imem_addr), 32'd3);

        stall = 1'b1;
        step(); check("st1_addr", 32'(imem_addr), 32'd3); check_ifid("st1", 19'd3, 12'd3, 1'b1);
        step(); check("st2_addr", 32'(imem_addr), 32'd3); check_ifid("st2", 19'd3, 12'd3, 1'b1);
        stall = 1'b0;
        step(); check_ifid("f4", 19'd4, 12'd4, 1'b1);
        step(); check_ifid("f5", 19'd5, 12'd5, 1'b1);
        step(); check_ifid("f6", 19'd6, 12'd6, 1'b1);
        check("f6_addr", 32'(imem_addr), 32'd6);

        // redirect wins over stall
        redirect = 1'b1; redirect_pc = 12'd100; stall = 1'b1;
        step(); check("rd_addr", 32'(imem_addr), 32'd100); check_ifid("rd_bub", 19'h0, 12'd6, 1'b0);
        redirect = 1'b0; stall = 1'b0;
        step(); check_ifid("rd_f", 19'd101, 12'd101, 1'b1);

        redirect = 1'b1; redirect_pc = 12'd7;
        step(); check("h_addr0", 32'(imem_addr), 32'd7);
        redirect = 1'b0;
        step(); check_ifid("h_fetch", 19'h7FFFF, 12'd8, 1'b1);
        check("h_halted", 32'(halted), 32'd1);
        check("h_addr1", 32'(imem_addr), 32'd7);
        step(); check_ifid("h_bub", 19'h0, 12'd8, 1'b0);
        check("h_addr2", 32'(imem_addr), 32'd7);
        check("h_halted2", 32'(halted), 32'd1);

        redirect = 1'b1; redirect_pc = 12'd20;
        step(); check("u_halted", 32'(halted), 32'd0); check("u_addr", 32'(imem_addr), 32'd20);
        redirect = 1'b0;
        step(); check_ifid("u_f", 19'd21, 12'd21, 1'b1);

        redirect = 1'b1; redirect_pc = 12'd4095;
        step(); check("w_addr0", 32'(imem_addr), 32'd4095);
        redirect = 1'b0;
        step(); check_ifid("w_f", 19'h01000, 12'd0, 1'b1);
        check("w_addr1", 32'(imem_addr), 32'd0);

`ifdef FETCH_PERF_CNT_EN
        check("cnt_stall", 32'(stall_cnt), 32'd2);
`endif

        redirect = 1'b1; redirect_pc = 12'd49;
        step();
        redirect = 1'b0;
        step(); check("ar_addr50", 32'(imem_addr), 32'd50);
        check("ar_valid1", 32'(ifid_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_addr", 32'(imem_addr), 32'd0);
        check("ar_valid", 32'(ifid_valid), 32'd0);
        check("ar_instr", 32'(ifid_instr), 32'd0);
        check("ar_halted", 32'(halted), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("ar_fcnt", 32'(fetch_cnt), 32'd0);
        check("ar_scnt", 32'(stall_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step(); check_ifid("ar_f1", 19'd1, 12'd1, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        check("ar_fcnt1", 32'(fetch_cnt), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
